imem_bank: RTL and testbench
============================

Name: imem_bank

Overview:
Parametrised instruction memory for the RISC-V core, replacing the fixed 64-word array. It provides a valid/ready fetch port with a 1-cycle registered response and back-pressure, and a byte-enabled program-load write port. Misaligned and out-of-range fetches return a fault flag. A sequential clear engine zeroes the array one word per cycle, either after reset or on command. The block sits between the PC/fetch stage and the IF/ID pipeline register.

Parameters:
DEPTH, 64, number of 32-bit words; power of two, >= 2; AW = log2(DEPTH)
ADDR_W, 32, width of byte addresses on the fetch and write ports
RESET_CLEAR, 1, 1 = enter CLEAR after reset; 0 = enter IDLE after reset (contents retained)
FAULT_INSTR, 32'h00000013, instruction returned on a faulting fetch (addi x0,x0,0)

Ports:
clk  in  1  clock; all logic on posedge
reset  in  1  synchronous, active-high
req_valid  in  1  fetch request valid
req_addr  in  ADDR_W  fetch byte address
req_ready  out  1  fetch request accepted when high together with req_valid
rsp_valid  out  1  response valid
rsp_instr  out  32  fetched instruction
rsp_fault  out  1  response is a fault (misaligned or out of range)
rsp_ready  in  1  consumer accepts the response
wr_en  in  1  program-load write strobe
wr_addr  in  ADDR_W  write byte address
wr_data  in  32  write data
wr_be  in  4  byte enables; bit i covers bits [8i+7:8i]
wr_err  out  1  one-cycle pulse: a write was dropped
clear_start  in  1  request a full clear
clear_busy  out  1  high while in CLEAR

Behaviour:
- Reset values: rsp_valid=0, rsp_instr=0, rsp_fault=0, wr_err=0, clear counter=0. State after reset is CLEAR if RESET_CLEAR=1, otherwise IDLE. Reset does not write the array directly.
- FSM has two states, IDLE and CLEAR. clear_busy = (state==CLEAR).
- CLEAR: each cycle writes 0 to mem[cnt] and increments cnt.
  - At cnt==DEPTH-1, writes the last word, goes to IDLE and resets cnt to 0.
  - A clear lasts exactly DEPTH cycles.
  - clear_start is ignored while in CLEAR; there is no restart.
  - Reset during CLEAR restarts the clear from cnt=0 if RESET_CLEAR=1; otherwise the clear is abandoned (partial clear) and the FSM goes to IDLE.
- IDLE: clear_start=1 moves to CLEAR on the next cycle. A fetch or write presented in the same cycle is still serviced.
- req_ready = (state==IDLE) && (!rsp_valid || rsp_ready). It is combinational and does not depend on req_valid.
- Fetch accept (req_valid && req_ready): the response is registered on the next edge, giving 1-cycle latency.
  - Fault when req_addr[1:0]!=0 or req_addr >= 4*DEPTH. The response then has rsp_fault=1 and rsp_instr=FAULT_INSTR.
  - Otherwise rsp_fault=0 and rsp_instr = mem[req_addr[AW+1:2]].
- Response hold: while rsp_valid && !rsp_ready, rsp_instr and rsp_fault remain stable.
  - rsp_valid clears on the edge where rsp_ready=1 and no new request is accepted.
  - Back-to-back fetches sustain 1 per cycle when rsp_ready=1.
- Write (wr_en in IDLE): mem[wr_addr[AW+1:2]] is updated only in the bytes selected by wr_be.
  - A misaligned or out-of-range wr_addr drops the write and sets wr_err=1 for the next cycle only.
  - wr_be=0 is a legal no-op with no error.
- Write during CLEAR is dropped and pulses wr_err. The clear write wins.
- Read and write to the same word in the same cycle: the fetch returns the old data (read-first). The new data is visible from the following fetch.
- clear_start and reset asserted together: reset wins.
- Array contents are undefined until cleared or loaded; the testbench must not rely on power-up values.

Test Plan:
- Reset with RESET_CLEAR=1, DEPTH=64 -> clear_busy=1 for exactly 64 cycles, req_ready=0 throughout; afterwards a fetch at 0x00 returns 0x00000000 with rsp_fault=0.
- Load 0x00100113 at wr_addr 0x04 with wr_be=4'hF, then fetch 0x04 -> rsp_valid one cycle after accept, rsp_instr=0x00100113.
- Partial write: wr_be=4'b0010, wr_data=0x0000AB00 to a word holding 0x00100113 -> fetch returns 0x0010AB13.
- Fetch 0x06, then fetch 0x100 (DEPTH=64) -> both responses have rsp_fault=1 and rsp_instr=0x00000013; writes to the same addresses pulse wr_err=1 for one cycle.
- Back-pressure: hold rsp_ready=0 for 3 cycles after accepting a fetch of 0x08 -> req_ready=0 and rsp_instr stays stable for those 3 cycles. Raising rsp_ready with a new request of 0x0C pending gives the 0x0C response on the next cycle, with no gap and no duplicate.
- Same-cycle fetch and write to 0x10 (old 0x11111111, new 0x22222222) -> response 0x11111111, next fetch 0x22222222. clear_start mid-stream, then reset at clear cycle 10 -> the clear restarts and clear_busy stays high for 64 more cycles.

Source files
------------

// File: rtl/imem_bank.sv
`default_nettype none
//============================================================================
// Module      : imem_bank
// Description : Parametrised instruction memory for the RISC-V core.
//               Sits between the PC/fetch stage and the IF/ID register.
//               - Fetch port: valid/ready request, 1-cycle registered
//                 response with back-pressure and a fault flag for
//                 misaligned or out-of-range addresses.
//               - Program-load port: byte-enabled word writes; dropped
//                 writes raise a one-cycle wr_err pulse.
//               - Clear engine: zeroes one word per cycle, after reset
//                 (RESET_CLEAR=1) or on clear_start.
// Ports       : clk, reset            clock / synchronous active-high reset
//               req_valid/addr/ready  fetch request handshake
//               rsp_valid/instr/fault fetch response, held until rsp_ready
//               rsp_ready             consumer accepts the response
//               wr_en/addr/data/be    program-load write
//               wr_err                pulse: a write was dropped
//               clear_start           request a full clear
//               clear_busy            high while clearing
// Revision    : 1.0 - initial release
//============================================================================
module imem_bank #(
    parameter int          DEPTH       = 64,
    parameter int          ADDR_W      = 32,
    parameter bit          RESET_CLEAR = 1'b1,
    parameter logic [31:0] FAULT_INSTR = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              reset,
    // fetch request
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              req_ready,
    // fetch response
    output logic              rsp_valid,
    output logic [31:0]       rsp_instr,
    output logic              rsp_fault,
    input  logic              rsp_ready,
    // program-load write
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [31:0]       wr_data,
    input  logic [3:0]        wr_be,
    output logic              wr_err,
    // clear engine
    input  logic              clear_start,
    output logic              clear_busy
);

    localparam int AW = $clog2(DEPTH);

    // State encoding
    localparam logic [0:0] c_IDLE  = 1'b0;
    localparam logic [0:0] c_CLEAR = 1'b1;

    localparam logic [AW-1:0] c_LAST = AW'(DEPTH - 1);

    //------------------------------------------------------------------
    // Storage and registers
    //------------------------------------------------------------------
    logic [31:0]   r_mem [DEPTH];
    logic [0:0]    r_state;
    logic [AW-1:0] r_cnt;
    logic          r_rsp_valid;
    logic [31:0]   r_rsp_instr;
    logic          r_rsp_fault;
    logic          r_wr_err;

    //------------------------------------------------------------------
    // Address decode
    //------------------------------------------------------------------
    logic          w_req_oob;
    logic          w_wr_oob;
    logic          w_req_bad;
    logic          w_wr_bad;
    logic [AW-1:0] w_req_idx;
    logic [AW-1:0] w_wr_idx;

    // Any address bit above the word-index field means the byte address
    // is at or beyond 4*DEPTH. If the port is not wider than the index
    // field, every address is in range.
    generate
        if (ADDR_W > AW + 2) begin : g_oob_check
            assign w_req_oob = |req_addr[ADDR_W-1:AW+2];
            assign w_wr_oob  = |wr_addr[ADDR_W-1:AW+2];
        end else begin : g_oob_none
            assign w_req_oob = 1'b0;
            assign w_wr_oob  = 1'b0;
        end
    endgenerate

    assign w_req_bad = (req_addr[1:0] != 2'b00) || w_req_oob;
    assign w_wr_bad  = (wr_addr[1:0]  != 2'b00) || w_wr_oob;
    assign w_req_idx = req_addr[AW+1:2];
    assign w_wr_idx  = wr_addr[AW+1:2];

    //------------------------------------------------------------------
    // Handshake and write qualification
    //------------------------------------------------------------------
    logic        w_idle;
    logic        w_fetch_go;
    logic        w_clr_we;
    logic        w_load_we;
    logic [31:0] w_wr_merged;

    assign w_idle     = (r_state == c_IDLE);
    // Ready is independent of req_valid: a new request may be taken when
    // the output slot is empty or is being drained this cycle.
    assign req_ready  = w_idle && (!r_rsp_valid || rsp_ready);
    assign w_fetch_go = req_valid && req_ready;

    assign w_clr_we  = (r_state == c_CLEAR);
    assign w_load_we = w_idle && wr_en && !w_wr_bad && (wr_be != 4'b0000);

    // Merge the enabled bytes into the current word contents.
    always_comb begin
        w_wr_merged = r_mem[w_wr_idx];
        for (int b = 0; b < 4; b++) begin
            if (wr_be[b]) begin
                w_wr_merged[8*b +: 8] = wr_data[8*b +: 8];
            end
        end
    end

    //------------------------------------------------------------------
    // Memory array (no reset; contents change only via writes/clear).
    // The clear write has priority; loads are already blocked in CLEAR.
    //------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (w_clr_we) begin
                r_mem[r_cnt] <= 32'h0000_0000;
            end else if (w_load_we) begin
                r_mem[w_wr_idx] <= w_wr_merged;
            end
        end
    end

    //------------------------------------------------------------------
    // Control FSM, response register and write-error pulse
    //------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= RESET_CLEAR ? c_CLEAR : c_IDLE;
            r_cnt       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_instr <= 32'h0000_0000;
            r_rsp_fault <= 1'b0;
            r_wr_err    <= 1'b0;
        end else begin
            // A write is dropped when it lands during a clear or targets
            // a misaligned / out-of-range address (even with wr_be=0).
            r_wr_err <= wr_en && (!w_idle || w_wr_bad);

            case (r_state)
                c_IDLE: begin
                    if (clear_start) begin
                        r_state <= c_CLEAR;
                        r_cnt   <= '0;
                    end
                end
                c_CLEAR: begin
                    if (r_cnt == c_LAST) begin
                        r_state <= c_IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                    r_cnt   <= '0;
                end
            endcase

            // Read-first: the array read here sees the pre-write value
            // of any load issued on the same edge.
            if (w_fetch_go) begin
                r_rsp_valid <= 1'b1;
                r_rsp_fault <= w_req_bad;
                r_rsp_instr <= w_req_bad ? FAULT_INSTR : r_mem[w_req_idx];
            end else if (rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    assign rsp_valid  = r_rsp_valid;
    assign rsp_instr  = r_rsp_instr;
    assign rsp_fault  = r_rsp_fault;
    assign wr_err     = r_wr_err;
    assign clear_busy = (r_state == c_CLEAR);

endmodule
`default_nettype wire

// File: tb/tb_imem_bank.sv
`default_nettype none
//============================================================================
// Module      : tb_imem_bank
// Description : Directed self-checking bench for imem_bank (DEPTH=64,
//               RESET_CLEAR=1). Inputs change 1 ns after each rising edge;
//               outputs are sampled in the same window.
// Revision    : 1.0 - initial release
//============================================================================
module tb_imem_bank;

    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_instr;
    logic        rsp_fault;
    logic        rsp_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;
    logic        wr_err;
    logic        clear_start;
    logic        clear_busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    imem_bank #(
        .DEPTH       (DEPTH),
        .ADDR_W      (32),
        .RESET_CLEAR (1'b1),
        .FAULT_INSTR (32'h0000_0013)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_addr    (req_addr),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_instr   (rsp_instr),
        .rsp_fault   (rsp_fault),
        .rsp_ready   (rsp_ready),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_be       (wr_be),
        .wr_err      (wr_err),
        .clear_start (clear_start),
        .clear_busy  (clear_busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One accepted fetch; response is checked one edge later.
    task automatic do_fetch(input string tag, input logic [31:0] a,
                            input logic [31:0] exp_instr, input logic exp_fault);
        req_valid = 1'b1;
        req_addr  = a;
        #1;
        chk({tag, "_ready"}, {31'b0, req_ready}, 32'd1);
        tick();
        req_valid = 1'b0;
        chk({tag, "_valid"}, {31'b0, rsp_valid}, 32'd1);
        chk({tag, "_instr"}, rsp_instr, exp_instr);
        chk({tag, "_fault"}, {31'b0, rsp_fault}, {31'b0, exp_fault});
    endtask

    // One write; checks wr_err on the following cycle and that it drops after.
    task automatic do_write(input string tag, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] be, input logic exp_err);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        wr_be   = be;
        tick();
        wr_en = 1'b0;
        chk({tag, "_err"}, {31'b0, wr_err}, {31'b0, exp_err});
        tick();
        chk({tag, "_err_off"}, {31'b0, wr_err}, 32'd0);
    endtask

    // Counts consecutive clear_busy cycles starting now; req_ready must stay low.
    task automatic count_clear(input string tag, output int n);
        int rdy_seen;
        n        = 0;
        rdy_seen = 0;
        while (clear_busy && n < 200) begin
            if (req_ready) rdy_seen++;
            if (n == 30) clear_start = 1'b0;
            n++;
            tick();
        end
        chk({tag, "_len"}, n, DEPTH);
        chk({tag, "_rdy_low"}, rdy_seen, 0);
    endtask

    initial begin
        int n;
        reset       = 1'b1;
        req_valid   = 1'b0;
        req_addr    = '0;
        rsp_ready   = 1'b1;
        wr_en       = 1'b0;
        wr_addr     = '0;
        wr_data     = '0;
        wr_be       = '0;
        clear_start = 1'b0;

        tick();
        tick();
        // Reset state
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_rsp_instr", rsp_instr, 32'd0);
        chk("rst_rsp_fault", {31'b0, rsp_fault}, 32'd0);
        chk("rst_wr_err",    {31'b0, wr_err}, 32'd0);
        chk("rst_busy",      {31'b0, clear_busy}, 32'd1);
        reset = 1'b0;

        // Power-up clear: exactly DEPTH cycles with req_ready low
        count_clear("pwr_clear", n);
        chk("pwr_clear_done", {31'b0, clear_busy}, 32'd0);
        do_fetch("f00", 32'h00, 32'h0000_0000, 1'b0);

        // Full-word load and fetch
        do_write("w04", 32'h04, 32'h0010_0113, 4'hF, 1'b0);
        do_fetch("f04", 32'h04, 32'h0010_0113, 1'b0);

        // Byte-lane 1 only
        do_write("w04p", 32'h04, 32'h0000_AB00, 4'b0010, 1'b0);
        do_fetch("f04p", 32'h04, 32'h0010_AB13, 1'b0);

        // Faulting fetches
        do_fetch("f06", 32'h06, 32'h0000_0013, 1'b1);
        do_fetch("f100", 32'h100, 32'h0000_0013, 1'b1);

        // Faulting writes are dropped (would alias onto words 1 and 0)
        do_write("w06", 32'h06, 32'hDEAD_BEEF, 4'hF, 1'b1);
        do_write("w100", 32'h100, 32'hCAFE_F00D, 4'hF, 1'b1);
        do_write("wbe0", 32'h08, 32'hFFFF_FFFF, 4'h0, 1'b0);
        do_fetch("f04_kept", 32'h04, 32'h0010_AB13, 1'b0);
        do_fetch("f00_kept", 32'h00, 32'h0000_0000, 1'b0);
        do_fetch("f08_be0", 32'h08, 32'h0000_0000, 1'b0);

        // Back-pressure
        do_write("w08", 32'h08, 32'hAAAA_5555, 4'hF, 1'b0);
        do_write("w0c", 32'h0C, 32'h0C0C_0C0C, 4'hF, 1'b0);
        chk("bp_idle", {31'b0, rsp_valid}, 32'd0);
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_addr  = 32'h08;
        tick();
        req_addr = 32'h0C;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_ready_low", {31'b0, req_ready}, 32'd0);
            chk("bp_valid",     {31'b0, rsp_valid}, 32'd1);
            chk("bp_instr",     rsp_instr, 32'hAAAA_5555);
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_release_ready", {31'b0, req_ready}, 32'd1);
        tick();
        req_valid = 1'b0;
        chk("bp_next_valid", {31'b0, rsp_valid}, 32'd1);
        chk("bp_next_instr", rsp_instr, 32'h0C0C_0C0C);
        tick();
        chk("bp_no_dup", {31'b0, rsp_valid}, 32'd0);

        // Same-cycle fetch and write: read-first
        do_write("w10", 32'h10, 32'h1111_1111, 4'hF, 1'b0);
        wr_en     = 1'b1;
        wr_addr   = 32'h10;
        wr_data   = 32'h2222_2222;
        wr_be     = 4'hF;
        req_valid = 1'b1;
        req_addr  = 32'h10;
        tick();
        wr_en     = 1'b0;
        req_valid = 1'b0;
        chk("rf_old", rsp_instr, 32'h1111_1111);
        chk("rf_err", {31'b0, wr_err}, 32'd0);
        do_fetch("rf_new", 32'h10, 32'h2222_2222, 1'b0);

        // clear_start with a fetch in the same cycle: fetch still serviced
        clear_start = 1'b1;
        req_valid   = 1'b1;
        req_addr    = 32'h10;
        tick();
        clear_start = 1'b0;
        chk("cs_busy",  {31'b0, clear_busy}, 32'd1);
        chk("cs_fetch", rsp_instr, 32'h2222_2222);
        chk("cs_ready", {31'b0, req_ready}, 32'd0);
        req_valid = 1'b0;
        // Write during clear is dropped with an error pulse
        wr_en   = 1'b1;
        wr_addr = 32'h20;
        wr_data = 32'h5555_5555;
        wr_be   = 4'hF;
        tick();
        wr_en = 1'b0;
        chk("clr_wr_err", {31'b0, wr_err}, 32'd1);
        for (int i = 1; i < 10; i++) tick();
        chk("cs_busy10", {31'b0, clear_busy}, 32'd1);

        // Reset at clear cycle 10 restarts the clear; clear_start held
        // high during it must not extend it.
        reset       = 1'b1;
        clear_start = 1'b1;
        tick();
        reset = 1'b0;
        chk("rr_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        count_clear("rst_clear", n);
        clear_start = 1'b0;
        do_fetch("post_clr10", 32'h10, 32'h0000_0000, 1'b0);
        do_fetch("post_clr04", 32'h04, 32'h0000_0000, 1'b0);
        do_fetch("post_clr20", 32'h20, 32'h0000_0000, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
